// File: rtl/nts_tx_packet_buffer.sv
// Single-packet transmit buffer: the engine fills one packet, the extractor drains it and releases it.
// Latency: commit visible 1 cycle after last write; read data registered 1 cycle after rd_en; no write backpressure beyond o_write_ready.
module nts_tx_packet_buffer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int MAC_DATA_WIDTH = 64
) (
    input  logic                      i_clk,
    input  logic                      i_areset,
    input  logic                      i_write_en,
    input  logic [MAC_DATA_WIDTH-1:0] i_write_data,
    input  logic                      i_write_last,
    input  logic [3:0]                i_write_bytes_last,
    input  logic                      i_write_discard,
    output logic                      o_write_ready,
    output logic                      o_overflow,
    output logic                      o_packet_available,
    input  logic                      i_packet_read,
    output logic                      o_fifo_empty,
    input  logic                      i_fifo_rd_en,
    output logic [MAC_DATA_WIDTH-1:0] o_fifo_rd_data,
    output logic [3:0]                o_bytes_last_word
);

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_FILL  = 2'd1;
    localparam logic [1:0] STATE_READY = 2'd2;

    localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [1:0]                state;
    logic [ADDR_WIDTH:0]       wr_ptr;
    logic [ADDR_WIDTH:0]       rd_ptr;
    logic [ADDR_WIDTH:0]       word_count;
    logic                      overflow_flag;
    logic                      overflow_pulse;
    logic [3:0]                bytes_last_word;
    logic [MAC_DATA_WIDTH-1:0] rd_data;
    logic [MAC_DATA_WIDTH-1:0] mem [DEPTH];

    logic write_accept;
    logic mem_we;
    logic rd_fire;
    logic fifo_empty;

    // wr_ptr is always 0 in IDLE, so it doubles as the store address there.
    assign write_accept = i_write_en && (state != STATE_READY)
                          && !((state == STATE_FILL) && i_write_discard);
    assign mem_we       = write_accept && (wr_ptr != PTR_FULL);
    assign fifo_empty   = (state != STATE_READY) || (rd_ptr == word_count);
    assign rd_fire      = (state == STATE_READY) && i_fifo_rd_en && !fifo_empty;

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_write_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state           <= STATE_IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            word_count      <= '0;
            overflow_flag   <= 1'b0;
            overflow_pulse  <= 1'b0;
            bytes_last_word <= 4'd0;
            rd_data         <= '0;
        end else begin
            overflow_pulse <= 1'b0;

            if (rd_fire) begin
                rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end

            case (state)
                STATE_IDLE: begin
                    if (i_write_en) begin
                        wr_ptr <= PTR_ONE;
                        if (i_write_last) begin
                            word_count      <= PTR_ONE;
                            bytes_last_word <= i_write_bytes_last;
                            state           <= STATE_READY;
                        end else begin
                            state <= STATE_FILL;
                        end
                    end
                end
                STATE_FILL: begin
                    if (i_write_discard) begin
                        state         <= STATE_IDLE;
                        wr_ptr        <= '0;
                        overflow_flag <= 1'b0;
                    end else if (i_write_en) begin
                        if (wr_ptr != PTR_FULL) begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end else begin
                            overflow_flag <= 1'b1;
                        end
                        // An oversized packet is only dropped once its last word arrives.
                        if (i_write_last) begin
                            if (overflow_flag || (wr_ptr == PTR_FULL)) begin
                                overflow_pulse <= 1'b1;
                                overflow_flag  <= 1'b0;
                                wr_ptr         <= '0;
                                state          <= STATE_IDLE;
                            end else begin
                                word_count      <= wr_ptr + 1'b1;
                                bytes_last_word <= i_write_bytes_last;
                                state           <= STATE_READY;
                            end
                        end
                    end
                end
                STATE_READY: begin
                    if (i_packet_read) begin
                        state           <= STATE_IDLE;
                        wr_ptr          <= '0;
                        rd_ptr          <= '0;
                        word_count      <= '0;
                        bytes_last_word <= 4'd0;
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

    assign o_write_ready      = (state != STATE_READY);
    assign o_overflow         = overflow_pulse;
    assign o_packet_available = (state == STATE_READY);
    assign o_fifo_empty       = fifo_empty;
    assign o_fifo_rd_data     = rd_data;
    assign o_bytes_last_word  = bytes_last_word;

endmodule

// File: tb/tb_nts_tx_packet_buffer.sv
// Bench for nts_tx_packet_buffer (16-word buffer): directed scenarios plus random traffic vs a queue model.
module tb_nts_tx_packet_buffer;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        i_areset = 1'b1;
    logic        i_write_en = 1'b0;
    logic [63:0] i_write_data = '0;
    logic        i_write_last = 1'b0;
    logic [3:0]  i_write_bytes_last = '0;
    logic        i_write_discard = 1'b0;
    logic        o_write_ready;
    logic        o_overflow;
    logic        o_packet_available;
    logic        i_packet_read = 1'b0;
    logic        o_fifo_empty;
    logic        i_fifo_rd_en = 1'b0;
    logic [63:0] o_fifo_rd_data;
    logic [3:0]  o_bytes_last_word;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    nts_tx_packet_buffer #(.ADDR_WIDTH(AW), .MAC_DATA_WIDTH(64)) dut (
        .i_clk(clk), .i_areset(i_areset),
        .i_write_en(i_write_en), .i_write_data(i_write_data), .i_write_last(i_write_last),
        .i_write_bytes_last(i_write_bytes_last), .i_write_discard(i_write_discard),
        .o_write_ready(o_write_ready), .o_overflow(o_overflow),
        .o_packet_available(o_packet_available), .i_packet_read(i_packet_read),
        .o_fifo_empty(o_fifo_empty), .i_fifo_rd_en(i_fifo_rd_en),
        .o_fifo_rd_data(o_fifo_rd_data), .o_bytes_last_word(o_bytes_last_word)
    );

    // Reference model: packet being filled and committed packet as queues of words.
    bit          m_ready;
    bit          m_ovf;
    bit          m_pulse;
    logic [63:0] m_fill[$];
    logic [63:0] m_pkt[$];
    int          m_rd;
    logic [3:0]  m_bytes;
    logic [63:0] m_rdata;

    task automatic model_step(input logic rst, we, wl, disc, pr, re,
                              input logic [63:0] wd, input logic [3:0] wb);
        if (rst) begin
            m_ready = 0; m_ovf = 0; m_pulse = 0; m_fill.delete(); m_pkt.delete();
            m_rd = 0; m_bytes = 0; m_rdata = '0;
            return;
        end
        m_pulse = 0;
        if (m_ready) begin
            if (re && m_rd < m_pkt.size()) begin
                m_rdata = m_pkt[m_rd];
                m_rd++;
            end
            if (pr) begin
                m_ready = 0; m_pkt.delete(); m_rd = 0; m_bytes = 0;
            end
        end else if (disc && (m_fill.size() > 0 || m_ovf)) begin
            m_fill.delete(); m_ovf = 0;
        end else if (we) begin
            if (m_fill.size() < DEPTH) m_fill.push_back(wd);
            else m_ovf = 1;
            if (wl) begin
                if (m_ovf) begin
                    m_pulse = 1; m_ovf = 0;
                end else begin
                    m_pkt = m_fill; m_ready = 1; m_bytes = wb; m_rd = 0;
                end
                m_fill.delete();
            end
        end
    endtask

    task automatic cyc(input logic rst, we, wl, disc, pr, re,
                       input logic [63:0] wd, input logic [3:0] wb);
        i_areset = rst; i_write_en = we; i_write_last = wl; i_write_discard = disc;
        i_packet_read = pr; i_fifo_rd_en = re; i_write_data = wd; i_write_bytes_last = wb;
        @(posedge clk);
        model_step(rst, we, wl, disc, pr, re, wd, wb);
        #1;
        i_areset = 0; i_write_en = 0; i_write_last = 0; i_write_discard = 0;
        i_packet_read = 0; i_fifo_rd_en = 0; i_write_data = '0; i_write_bytes_last = '0;
    endtask

    task automatic wr(input logic [63:0] d, input logic last, input logic [3:0] b);
        cyc(0, 1, last, 0, 0, 0, d, b);
    endtask

    task automatic rd();
        cyc(0, 0, 0, 0, 0, 1, '0, '0);
    endtask

    task automatic release_pkt();
        cyc(0, 0, 0, 0, 1, 0, '0, '0);
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 0, '0, '0);
        cyc(1, 0, 0, 0, 0, 0, '0, '0);
        tests_run++; if (o_write_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_write_ready: got %b expected 1", o_write_ready); end
        tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", o_overflow); end
        tests_run++; if (o_packet_available !== 1'b0) begin tests_failed++; $display("FAIL reset_avail: got %b expected 0", o_packet_available); end
        tests_run++; if (o_fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1", o_fifo_empty); end
        tests_run++; if (o_fifo_rd_data !== 64'd0) begin tests_failed++; $display("FAIL reset_rd_data: got %h expected 0", o_fifo_rd_data); end
        tests_run++; if (o_bytes_last_word !== 4'd0) begin tests_failed++; $display("FAIL reset_bytes: got %0d expected 0", o_bytes_last_word); end
    endtask

    task automatic test_basic();
        wr(64'h1111_1111_1111_1111, 0, 0);
        wr(64'h2222_2222_2222_2222, 0, 0);
        wr(64'h3333_3333_3333_3333, 1, 5);
        tests_run++; if (o_packet_available !== 1'b1) begin tests_failed++; $display("FAIL basic_avail: got %b expected 1", o_packet_available); end
        tests_run++; if (o_fifo_empty !== 1'b0) begin tests_failed++; $display("FAIL basic_empty: got %b expected 0", o_fifo_empty); end
        tests_run++; if (o_bytes_last_word !== 4'd5) begin tests_failed++; $display("FAIL basic_bytes: got %0d expected 5", o_bytes_last_word); end
        tests_run++; if (o_write_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_write_ready: got %b expected 0", o_write_ready); end
        rd();
        tests_run++; if (o_fifo_rd_data !== 64'h1111_1111_1111_1111) begin tests_failed++; $display("FAIL basic_rd0: got %h expected 1111111111111111", o_fifo_rd_data); end
        tests_run++; if (o_fifo_empty !== 1'b0) begin tests_failed++; $display("FAIL basic_empty0: got %b expected 0", o_fifo_empty); end
        rd();
        tests_run++; if (o_fifo_rd_data !== 64'h2222_2222_2222_2222) begin tests_failed++; $display("FAIL basic_rd1: got %h expected 2222222222222222", o_fifo_rd_data); end
        rd();
        tests_run++; if (o_fifo_rd_data !== 64'h3333_3333_3333_3333) begin tests_failed++; $display("FAIL basic_rd2: got %h expected 3333333333333333", o_fifo_rd_data); end
        tests_run++; if (o_fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL basic_empty_end: got %b expected 1", o_fifo_empty); end
        rd();
        tests_run++; if (o_fifo_rd_data !== 64'h3333_3333_3333_3333) begin tests_failed++; $display("FAIL basic_rd_extra: got %h expected 3333333333333333", o_fifo_rd_data); end
        release_pkt();
        tests_run++; if (o_packet_available !== 1'b0) begin tests_failed++; $display("FAIL basic_release_avail: got %b expected 0", o_packet_available); end
        tests_run++; if (o_bytes_last_word !== 4'd0) begin tests_failed++; $display("FAIL basic_release_bytes: got %0d expected 0", o_bytes_last_word); end
    endtask

    task automatic test_single();
        wr(64'hCAFE_F00D_DEAD_BEEF, 1, 8);
        tests_run++; if (o_packet_available !== 1'b1) begin tests_failed++; $display("FAIL single_avail: got %b expected 1", o_packet_available); end
        tests_run++; if (o_bytes_last_word !== 4'd8) begin tests_failed++; $display("FAIL single_bytes: got %0d expected 8", o_bytes_last_word); end
        rd();
        tests_run++; if (o_fifo_rd_data !== 64'hCAFE_F00D_DEAD_BEEF) begin tests_failed++; $display("FAIL single_rd: got %h expected cafef00ddeadbeef", o_fifo_rd_data); end
        tests_run++; if (o_fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL single_empty: got %b expected 1", o_fifo_empty); end
        release_pkt();
        tests_run++; if (o_packet_available !== 1'b0) begin tests_failed++; $display("FAIL single_release_avail: got %b expected 0", o_packet_available); end
        tests_run++; if (o_write_ready !== 1'b1) begin tests_failed++; $display("FAIL single_release_ready: got %b expected 1", o_write_ready); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= DEPTH; i++) wr(64'(i + 100), (i == DEPTH), 3);
        tests_run++; if (o_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_pulse: got %b expected 1", o_overflow); end
        tests_run++; if (o_packet_available !== 1'b0) begin tests_failed++; $display("FAIL ovf_avail: got %b expected 0", o_packet_available); end
        tests_run++; if (o_write_ready !== 1'b1) begin tests_failed++; $display("FAIL ovf_ready: got %b expected 1", o_write_ready); end
        cyc(0, 0, 0, 0, 0, 0, '0, '0);
        tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_pulse_end: got %b expected 0", o_overflow); end
        wr(64'hA0A0, 0, 0);
        wr(64'hB0B0, 1, 2);
        tests_run++; if (o_packet_available !== 1'b1) begin tests_failed++; $display("FAIL ovf_next_avail: got %b expected 1", o_packet_available); end
        rd();
        tests_run++; if (o_fifo_rd_data !== 64'hA0A0) begin tests_failed++; $display("FAIL ovf_next_rd0: got %h expected a0a0", o_fifo_rd_data); end
        rd();
        tests_run++; if (o_fifo_rd_data !== 64'hB0B0) begin tests_failed++; $display("FAIL ovf_next_rd1: got %h expected b0b0", o_fifo_rd_data); end
        tests_run++; if (o_fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL ovf_next_empty: got %b expected 1", o_fifo_empty); end
        release_pkt();
        // Exactly DEPTH words is the largest packet that fits.
        for (int i = 0; i < DEPTH; i++) wr(64'(i + 500), (i == DEPTH - 1), 1);
        tests_run++; if (o_packet_available !== 1'b1 || o_overflow !== 1'b0) begin tests_failed++; $display("FAIL full_commit: got avail=%b ovf=%b expected 1 0", o_packet_available, o_overflow); end
        for (int i = 0; i < DEPTH; i++) rd();
        tests_run++; if (o_fifo_rd_data !== 64'(DEPTH - 1 + 500) || o_fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL full_last_word: got %h empty=%b expected %h 1", o_fifo_rd_data, o_fifo_empty, 64'(DEPTH - 1 + 500)); end
        release_pkt();
    endtask

    task automatic test_discard();
        wr(64'h0D1, 0, 0);
        wr(64'h0D2, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 64'h0D3, 0);
        tests_run++; if (o_packet_available !== 1'b0 || o_write_ready !== 1'b1) begin tests_failed++; $display("FAIL discard_state: got avail=%b ready=%b expected 0 1", o_packet_available, o_write_ready); end
        wr(64'hD0D0, 0, 0);
        wr(64'hE0E0, 1, 4);
        wr(64'hF0F0, 1, 7);
        tests_run++; if (o_bytes_last_word !== 4'd4) begin tests_failed++; $display("FAIL ready_write_bytes: got %0d expected 4", o_bytes_last_word); end
        rd();
        tests_run++; if (o_fifo_rd_data !== 64'hD0D0) begin tests_failed++; $display("FAIL discard_rd0: got %h expected d0d0", o_fifo_rd_data); end
        rd();
        tests_run++; if (o_fifo_rd_data !== 64'hE0E0) begin tests_failed++; $display("FAIL discard_rd1: got %h expected e0e0", o_fifo_rd_data); end
        tests_run++; if (o_fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL discard_empty: got %b expected 1", o_fifo_empty); end
        release_pkt();
    endtask

    task automatic test_reset_mid_drain();
        wr(64'h71, 0, 0);
        wr(64'h72, 0, 0);
        wr(64'h73, 1, 6);
        rd();
        tests_run++; if (o_fifo_rd_data !== 64'h71) begin tests_failed++; $display("FAIL middrain_rd0: got %h expected 71", o_fifo_rd_data); end
        cyc(1, 0, 0, 0, 0, 1, '0, '0);
        tests_run++; if (o_packet_available !== 1'b0 || o_fifo_empty !== 1'b1 || o_write_ready !== 1'b1) begin tests_failed++; $display("FAIL middrain_flags: got avail=%b empty=%b ready=%b expected 0 1 1", o_packet_available, o_fifo_empty, o_write_ready); end
        tests_run++; if (o_fifo_rd_data !== 64'd0 || o_bytes_last_word !== 4'd0 || o_overflow !== 1'b0) begin tests_failed++; $display("FAIL middrain_data: got rd=%h bytes=%0d ovf=%b expected 0 0 0", o_fifo_rd_data, o_bytes_last_word, o_overflow); end
        wr(64'h81, 0, 0);
        wr(64'h82, 1, 6);
        rd();
        tests_run++; if (o_fifo_rd_data !== 64'h81) begin tests_failed++; $display("FAIL middrain_new_rd0: got %h expected 81", o_fifo_rd_data); end
        rd();
        tests_run++; if (o_fifo_rd_data !== 64'h82) begin tests_failed++; $display("FAIL middrain_new_rd1: got %h expected 82", o_fifo_rd_data); end
        // Release in the same cycle as a read: the read still returns data.
        release_pkt();
        wr(64'h91, 0, 0);
        wr(64'h92, 1, 1);
        cyc(0, 0, 0, 0, 1, 1, '0, '0);
        tests_run++; if (o_fifo_rd_data !== 64'h91 || o_packet_available !== 1'b0) begin tests_failed++; $display("FAIL read_with_release: got rd=%h avail=%b expected 91 0", o_fifo_rd_data, o_packet_available); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            logic rst, we, wl, disc, pr, re;
            logic [63:0] wd;
            logic [3:0]  wb;
            rst  = ($urandom_range(199) == 0);
            we   = ($urandom_range(9) < 7);
            wl   = ($urandom_range(13) == 0);
            disc = ($urandom_range(59) == 0);
            pr   = ($urandom_range(11) == 0);
            re   = ($urandom_range(1) == 0);
            wd   = {$urandom, $urandom};
            wb   = 4'($urandom_range(8, 1));
            cyc(rst, we, wl, disc, pr, re, wd, wb);
            tests_run++; if (o_write_ready !== !m_ready) begin tests_failed++; $display("FAIL rand_ready @%0d: got %b expected %b", n, o_write_ready, !m_ready); end
            tests_run++; if (o_overflow !== m_pulse) begin tests_failed++; $display("FAIL rand_overflow @%0d: got %b expected %b", n, o_overflow, m_pulse); end
            tests_run++; if (o_packet_available !== m_ready) begin tests_failed++; $display("FAIL rand_avail @%0d: got %b expected %b", n, o_packet_available, m_ready); end
            tests_run++; if (o_fifo_empty !== (!m_ready || m_rd == m_pkt.size())) begin tests_failed++; $display("FAIL rand_empty @%0d: got %b expected %b", n, o_fifo_empty, (!m_ready || m_rd == m_pkt.size())); end
            tests_run++; if (o_fifo_rd_data !== m_rdata) begin tests_failed++; $display("FAIL rand_rd_data @%0d: got %h expected %h", n, o_fifo_rd_data, m_rdata); end
            tests_run++; if (o_bytes_last_word !== m_bytes) begin tests_failed++; $display("FAIL rand_bytes @%0d: got %0d expected %0d", n, o_bytes_last_word, m_bytes); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_overflow();
        test_discard();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nts_tx_packet_buffer.md
Name: nts_tx_packet_buffer

Overview:
Single-packet transmit buffer between an NTS engine's response builder (write side) and the extractor (read side).
- The engine streams 64-bit response words in and commits the packet with a last flag.
- The extractor sees the committed packet and drains it word by word: packet_available, fifo_empty, fifo_rd_en, bytes_last_word.
- The extractor releases the buffer with a packet_read pulse.
- This block is the responder end of the extractor's engine-side interface.

Parameters:
- ADDR_WIDTH, 8, log2 of buffer depth in 64-bit words (DEPTH = 2**ADDR_WIDTH).
- MAC_DATA_WIDTH, 64, word width. Only 64 is supported.

Ports:
- i_clk  in  1  clock.
- i_areset  in  1  reset. Synchronous to i_clk, active-high.
- i_write_en  in  1  write strobe for one word.
- i_write_data  in  MAC_DATA_WIDTH  write word.
- i_write_last  in  1  qualifies i_write_en: this word ends the packet.
- i_write_bytes_last  in  4  valid bytes in the last word, 1..8. Sampled with i_write_last.
- i_write_discard  in  1  abort the packet being filled.
- o_write_ready  out  1  buffer accepts writes.
- o_overflow  out  1  one-cycle pulse: packet dropped because it exceeded DEPTH words.
- o_packet_available  out  1  committed packet present.
- i_packet_read  in  1  one-cycle pulse: extractor finished with the packet and releases the buffer.
- o_fifo_empty  out  1  no unread words remain.
- i_fifo_rd_en  in  1  read one word.
- o_fifo_rd_data  out  MAC_DATA_WIDTH  read word.
- o_bytes_last_word  out  4  valid bytes in the final word of the committed packet.

Behaviour:
- States: IDLE (empty), FILL (receiving), READY (committed, readable).
- Reset (synchronous, i_areset high at a rising edge) from any state, mid-write or mid-read:
  - state goes to IDLE; pointers and word count go to 0; overflow flag cleared.
  - Outputs after reset: o_write_ready=1, o_overflow=0, o_packet_available=0, o_fifo_empty=1, o_fifo_rd_data=0, o_bytes_last_word=0.
- Write pointer and word count are ADDR_WIDTH+1 bits wide.
- o_write_ready=1 in IDLE and FILL; 0 in READY. i_write_en while not ready is ignored with no side effects.
- IDLE:
  - i_write_en stores the word at address 0 and sets wr_ptr=1.
  - Next state is READY if i_write_last, else FILL.
- FILL, on i_write_en:
  - If wr_ptr<DEPTH, store the word and increment wr_ptr.
  - If wr_ptr==DEPTH, set the sticky overflow flag and do not store the word.
- FILL, on i_write_en with i_write_last:
  - Overflow flag set (including set this cycle): pulse o_overflow for one cycle, go to IDLE, reset pointers.
  - Otherwise: word_count = wr_ptr+1, latch o_bytes_last_word = i_write_bytes_last, go to READY.
- i_write_discard in FILL goes to IDLE and clears pointers and flag. It takes priority over a simultaneous i_write_en. It is ignored in IDLE and READY.
- Commit timing: o_packet_available=1 and o_fifo_empty=0 from the cycle after the committing write.
- READY:
  - o_fifo_empty = (rd_ptr == word_count).
  - i_fifo_rd_en with !o_fifo_empty: read buffer[rd_ptr], increment rd_ptr.
  - o_fifo_rd_data is registered and updates exactly 1 cycle after i_fifo_rd_en.
  - o_fifo_empty reflects the incremented rd_ptr in that same following cycle.
  - Back-to-back rd_en every cycle is supported.
  - i_fifo_rd_en while o_fifo_empty=1 is ignored; o_fifo_rd_data holds its value.
- i_packet_read:
  - In READY, go to IDLE next cycle: o_packet_available=0, o_fifo_empty=1, o_bytes_last_word=0, pointers cleared, o_write_ready=1. This holds even if words remain unread.
  - A simultaneous i_fifo_rd_en is still honoured for that cycle's data.
  - Outside READY, i_packet_read is ignored.
- i_write_bytes_last outside 1..8 is stored unmodified; the producer guarantees range.
- Buffer is single-port write / single-port read inferred RAM. Write and read never target the same packet concurrently.

Test Plan:
- Reset, then write 3 words 0x1111..,0x2222..,0x3333.. with last and bytes_last=5 -> next cycle o_packet_available=1, o_fifo_empty=0, o_bytes_last_word=5, o_write_ready=0.
- Drain with rd_en held for 3 cycles -> o_fifo_rd_data = 0x1111..,0x2222..,0x3333.. on cycles +1,+2,+3; o_fifo_empty=1 from cycle +3; a 4th rd_en leaves data at 0x3333...
- Single-word packet from IDLE (write_en+last, bytes_last=8) -> READY with word_count 1; read returns the word; i_packet_read pulse -> o_packet_available=0, o_write_ready=1 next cycle.
- ADDR_WIDTH=4: write 17 words, 17th with last -> one-cycle o_overflow pulse, o_packet_available stays 0, o_write_ready=1. A following 2-word packet is delivered intact.
- Write 2 words, then assert i_write_discard together with i_write_en -> IDLE, nothing committed. Write while READY -> ignored; read data unchanged.
- Assert i_areset mid-drain after 1 of 3 words read -> all outputs at reset values next cycle; a new packet then reads from address 0.
